// File: rtl/eth_tx_pkg.sv
// rtl/eth_tx_pkg.sv - shared defaults and FSM state type for the Ethernet TX streamer (ETH_TX_PAD_EN adds PAD state)
package eth_tx_pkg;

  localparam int unsigned ADDR_WIDTH_DEF    = 11;
  localparam int unsigned MIN_FRAME_LEN_DEF = 60;

`ifdef ETH_TX_PAD_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_PAD    = 2'd2,
    ST_FLUSH  = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd3
  } state_e;
`endif

endpackage

// File: rtl/eth_tx_skid.sv
// rtl/eth_tx_skid.sv - 2-entry FIFO holding buffer read bytes ahead of the MAC handshake
module eth_tx_skid #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [Width-1:0] mem_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       cnt_q;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == 2'd0);
  assign full_o  = (cnt_q == 2'd2);
  assign data_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is only legal when the head leaves in the same cycle
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointer/count update; flush wins over any simultaneous push or pop
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else if (flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      if (do_push && !do_pop) begin
        cnt_q <= cnt_q + 2'd1;
      end else if (do_pop && !do_push) begin
        cnt_q <= cnt_q - 2'd1;
      end
    end
  end

endmodule

// File: rtl/eth_tx_streamer.sv
// rtl/eth_tx_streamer.sv - streams a buffered frame to the MAC byte by byte; ETH_TX_PAD_EN enables zero padding to MinFrameLen
module eth_tx_streamer
  import eth_tx_pkg::*;
#(
  parameter int unsigned AddrWidth   = ADDR_WIDTH_DEF,
  parameter int unsigned MinFrameLen = MIN_FRAME_LEN_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] len_i,
  input  logic                 abort_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 mem_en_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  input  logic [7:0]           mem_rdata_i,
  output logic [7:0]           tx_data_o,
  output logic                 tx_valid_o,
  output logic                 tx_last_o,
  input  logic                 tx_ready_i
);

  localparam logic [AddrWidth-1:0] AddrOne = AddrWidth'(1);
`ifdef ETH_TX_PAD_EN
  localparam logic [AddrWidth-1:0] MinLen = AddrWidth'(MinFrameLen);
`endif

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] len_q, len_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [AddrWidth-1:0] sent_q, sent_d;
  logic                 inflight_q, inflight_d;

  logic                 fifo_full, fifo_empty, fifo_pop, fifo_flush;
  logic [7:0]           fifo_data;
  logic [2:0]           fifo_level, slots_used;
  logic                 tx_hs, mem_issue;
  logic [AddrWidth-1:0] last_idx;

  assign tx_hs      = tx_valid_o && tx_ready_i;
  assign fifo_pop   = tx_hs && (state_q == ST_STREAM);
  assign fifo_flush = abort_i && (state_q != ST_IDLE);

  // Count the slot freed by a pop this cycle so a steady stream keeps one read going every cycle
  assign fifo_level = fifo_full ? 3'd2 : (fifo_empty ? 3'd0 : 3'd1);
  assign slots_used = fifo_level + {2'b00, inflight_q} - {2'b00, fifo_pop};
  assign mem_issue  = (state_q == ST_STREAM) && !abort_i && (addr_q < len_q) && (slots_used < 3'd2);

  assign mem_en_o   = mem_issue;
  assign mem_addr_o = addr_q;
  assign busy_o     = (state_q != ST_IDLE);
  assign done_o     = (state_q == ST_FLUSH);

`ifdef ETH_TX_PAD_EN
  assign last_idx = (len_q < MinLen) ? (MinLen - AddrOne) : (len_q - AddrOne);
`else
  assign last_idx = len_q - AddrOne;
`endif

  eth_tx_skid #(
    .Width(8)
  ) u_skid (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .flush_i(fifo_flush),
    .push_i (inflight_q),
    .data_i (mem_rdata_i),
    .pop_i  (fifo_pop),
    .data_o (fifo_data),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  // MAC-side outputs: FIFO head while streaming, constant zero bytes while padding
  always_comb begin
    tx_valid_o = 1'b0;
    tx_data_o  = 8'h00;
    case (state_q)
      ST_STREAM: begin
        tx_valid_o = !fifo_empty;
        tx_data_o  = fifo_empty ? 8'h00 : fifo_data;
      end
`ifdef ETH_TX_PAD_EN
      ST_PAD: begin
        tx_valid_o = 1'b1;
      end
`endif
      default: begin
        tx_valid_o = 1'b0;
      end
    endcase
    tx_last_o = tx_valid_o && (sent_q == last_idx);
  end

  // Next-state logic; abort beats everything, including a start in the same cycle
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    addr_d     = addr_q;
    sent_d     = sent_q;
    inflight_d = mem_issue;
    case (state_q)
      ST_IDLE: begin
        if (start_i && !abort_i && (len_i != '0)) begin
          state_d = ST_STREAM;
          len_d   = len_i;
          addr_d  = '0;
          sent_d  = '0;
        end
      end
      ST_STREAM: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else begin
          if (mem_issue) begin
            addr_d = addr_q + AddrOne;
          end
          if (tx_hs) begin
            sent_d = sent_q + AddrOne;
            if (sent_q == len_q - AddrOne) begin
`ifdef ETH_TX_PAD_EN
              state_d = (len_q < MinLen) ? ST_PAD : ST_FLUSH;
`else
              state_d = ST_FLUSH;
`endif
            end
          end
        end
      end
`ifdef ETH_TX_PAD_EN
      ST_PAD: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (tx_hs) begin
          sent_d = sent_q + AddrOne;
          if (tx_last_o) begin
            state_d = ST_FLUSH;
          end
        end
      end
`endif
      ST_FLUSH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      addr_q     <= '0;
      sent_q     <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      sent_q     <= sent_d;
      inflight_q <= inflight_d;
    end
  end

endmodule

// File: tb/tb_eth_tx_streamer.sv
// tb/tb_eth_tx_streamer.sv - self-checking bench for eth_tx_streamer (expectations follow ETH_TX_PAD_EN)
module tb_eth_tx_streamer;

  localparam int AW = 11;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          start_i;
  logic [AW-1:0] len_i;
  logic          abort_i;
  logic          busy_o, done_o, mem_en_o;
  logic [AW-1:0] mem_addr_o;
  logic [7:0]    mem_rdata_i;
  logic [7:0]    tx_data_o;
  logic          tx_valid_o, tx_last_o, tx_ready_i;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [2048];

  eth_tx_streamer #(
    .AddrWidth  (AW),
    .MinFrameLen(60)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .len_i      (len_i),
    .abort_i    (abort_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .mem_en_o   (mem_en_o),
    .mem_addr_o (mem_addr_o),
    .mem_rdata_i(mem_rdata_i),
    .tx_data_o  (tx_data_o),
    .tx_valid_o (tx_valid_o),
    .tx_last_o  (tx_last_o),
    .tx_ready_i (tx_ready_i)
  );

  always #5 clk_i = ~clk_i;

  // Frame buffer with one-cycle read latency
  always @(posedge clk_i) begin
    if (mem_en_o) mem_rdata_i <= mem[mem_addr_o];
  end

  typedef struct {
    int         len;
    int         mode;       // 0: ready high, 1: ready toggles, 2: ready high + start pulsed while busy
    int         exp_total;
    int         exp_reads;
    logic [7:0] exp_last;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] buf_byte(input int i);
    return 8'((i + 1) * 17);
  endfunction

  task automatic run_frame(input int len, input int mode, input int exp_total,
                           input int exp_reads, input logic [7:0] exp_last, input string tag);
    int         idx, reads, cyc, first_cyc, done_cyc;
    bit         finished, addr_ok, stalled;
    logic [7:0] held_data, last_data, exp_b;
    logic       held_last;
    idx = 0; reads = 0; cyc = 1; first_cyc = -1; done_cyc = -1;
    finished = 0; addr_ok = 1; stalled = 0; held_data = 0; held_last = 0; last_data = 0;
    @(negedge clk_i);
    start_i = 1'b1; len_i = AW'(len); tx_ready_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    #1;
    chk({tag, " busy_rise"}, 32'(busy_o), 32'd1);
    while (!finished && cyc < len * 3 + 400) begin
      tx_ready_i = (mode == 1) ? cyc[0] : 1'b1;
      if (mode == 2 && cyc == 4) begin
        start_i = 1'b1; len_i = AW'(3);
      end else begin
        start_i = 1'b0;
      end
      #1;
      if (mode == 2 && cyc == 5) chk({tag, " busy_held"}, 32'(busy_o), 32'd1);
      if (mem_en_o) begin
        if (32'(mem_addr_o) != 32'(reads)) addr_ok = 0;
        reads++;
      end
      if (stalled) begin
        chk({tag, " stall_valid"}, 32'(tx_valid_o), 32'd1);
        chk({tag, " stall_data"}, 32'(tx_data_o), 32'(held_data));
        chk({tag, " stall_last"}, 32'(tx_last_o), 32'(held_last));
      end
      if (tx_valid_o) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (tx_ready_i) begin
          exp_b = (idx < len) ? buf_byte(idx) : 8'h00;
          chk($sformatf("%s byte%0d", tag, idx), 32'(tx_data_o), 32'(exp_b));
          chk($sformatf("%s last%0d", tag, idx), 32'(tx_last_o), 32'(idx == exp_total - 1));
          last_data = tx_data_o;
          idx++;
        end
      end
      stalled   = tx_valid_o && !tx_ready_i;
      held_data = tx_data_o;
      held_last = tx_last_o;
      if (done_o) begin
        done_cyc = cyc;
        finished = 1;
      end else begin
        @(negedge clk_i);
        cyc++;
      end
    end
    start_i = 1'b0;
    chk({tag, " done_seen"}, 32'(finished), 32'd1);
    chk({tag, " byte_count"}, 32'(idx), 32'(exp_total));
    chk({tag, " read_count"}, 32'(reads), 32'(exp_reads));
    chk({tag, " read_addr_seq"}, 32'(addr_ok), 32'd1);
    chk({tag, " last_byte"}, 32'(last_data), 32'(exp_last));
    if (mode != 1) begin
      chk({tag, " first_valid_cyc"}, 32'(first_cyc), 32'd3);
      chk({tag, " done_cyc"}, 32'(done_cyc), 32'(3 + exp_total));
    end
    @(negedge clk_i);
    #1;
    chk({tag, " busy_fall"}, 32'(busy_o), 32'd0);
    chk({tag, " done_single"}, 32'(done_o), 32'd0);
  endtask

  initial begin
    int dones;
`ifdef ETH_TX_PAD_EN
    vecs[0] = '{4, 0, 60, 4, 8'h00};
    vecs[1] = '{8, 1, 60, 8, 8'h00};
    vecs[2] = '{10, 0, 60, 10, 8'h00};
    vecs[3] = '{1, 0, 60, 1, 8'h00};
    vecs[4] = '{3, 1, 60, 3, 8'h00};
    vecs[5] = '{6, 2, 60, 6, 8'h00};
    vecs[6] = '{2047, 0, 2047, 2047, 8'hEF};
`else
    vecs[0] = '{4, 0, 4, 4, 8'h44};
    vecs[1] = '{8, 1, 8, 8, 8'h88};
    vecs[2] = '{10, 0, 10, 10, 8'hAA};
    vecs[3] = '{1, 0, 1, 1, 8'h11};
    vecs[4] = '{3, 1, 3, 3, 8'h33};
    vecs[5] = '{6, 2, 6, 6, 8'h66};
    vecs[6] = '{2047, 0, 2047, 2047, 8'hEF};
`endif
    for (int i = 0; i < 2048; i++) mem[i] = buf_byte(i);

    rst_ni = 1'b0; start_i = 1'b0; len_i = '0; abort_i = 1'b0; tx_ready_i = 1'b1;
    #1;
    chk("reset_ctrl", {28'd0, busy_o, done_o, mem_en_o, tx_valid_o}, 32'd0);
    chk("reset_last", 32'(tx_last_o), 32'd0);
    chk("reset_addr_data", {13'd0, mem_addr_o, tx_data_o}, 32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int v = 0; v < 7; v++) begin
      run_frame(vecs[v].len, vecs[v].mode, vecs[v].exp_total, vecs[v].exp_reads,
                vecs[v].exp_last, $sformatf("vec%0d", v));
    end

    // len 0 start is ignored
    @(negedge clk_i);
    start_i = 1'b1; len_i = '0;
    @(negedge clk_i);
    start_i = 1'b0;
    #1;
    chk("len0_busy", 32'(busy_o), 32'd0);
    chk("len0_mem_en", 32'(mem_en_o), 32'd0);

    // abort and start together: abort wins
    @(negedge clk_i);
    start_i = 1'b1; abort_i = 1'b1; len_i = AW'(5);
    @(negedge clk_i);
    start_i = 1'b0; abort_i = 1'b0;
    #1;
    chk("abort_start_busy", 32'(busy_o), 32'd0);

    // abort while byte 3 of a 20-byte frame is on the bus
    @(negedge clk_i);
    start_i = 1'b1; len_i = AW'(20); tx_ready_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_i);
      start_i = 1'b0;
    end
    #1;
    chk("abort_pre_valid", 32'(tx_valid_o), 32'd1);
    chk("abort_pre_data", 32'(tx_data_o), 32'h44);
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    #1;
    chk("abort_valid_low", 32'(tx_valid_o), 32'd0);
    chk("abort_busy_low", 32'(busy_o), 32'd0);
    dones = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_i);
      if (done_o) dones++;
    end
    chk("abort_no_done", 32'(dones), 32'd0);
`ifdef ETH_TX_PAD_EN
    run_frame(2, 0, 60, 2, 8'h00, "post_abort");
`else
    run_frame(2, 0, 2, 2, 8'h22, "post_abort");
`endif

    // reset in the middle of a frame
    @(negedge clk_i);
    start_i = 1'b1; len_i = AW'(20);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      start_i = 1'b0;
    end
    #1;
    chk("rst_pre_valid", 32'(tx_valid_o), 32'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("rst_async_ctrl", {27'd0, busy_o, done_o, mem_en_o, tx_valid_o, tx_last_o}, 32'd0);
    chk("rst_async_addr_data", {13'd0, mem_addr_o, tx_data_o}, 32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    dones = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_i);
      if (done_o || busy_o) dones++;
    end
    chk("rst_idle_after", 32'(dones), 32'd0);
`ifdef ETH_TX_PAD_EN
    run_frame(4, 0, 60, 4, 8'h00, "post_reset");
`else
    run_frame(4, 0, 4, 4, 8'h44, "post_reset");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
